// File: rtl/micromind_count_ctrl.sv
`default_nettype none
// ============================================================================
// micromind_count_ctrl: command-driven up-counter sequencer with prescaler,
// terminal-count tick and one-shot/periodic modes.
// Optional feature macro: MICROMIND_COUNT_CAPTURE_EN (count snapshot port).
// Revision: 1.0
// ============================================================================
module micromind_count_ctrl #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [WIDTH-1:0]      period,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  periodic,
`ifdef MICROMIND_COUNT_CAPTURE_EN
   input  logic                  capture,
   output logic [WIDTH-1:0]      cap_value,
   output logic                  cap_valid,
`endif
   output logic [WIDTH-1:0]      count,
   output logic                  tick,
   output logic                  busy,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10,
      ST_DONE   = 2'b11
   } state_e;

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_STOP   = 2'b01;
   localparam logic [1:0] OP_PAUSE  = 2'b10;
   localparam logic [1:0] OP_RESUME = 2'b11;

   localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
   localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

   state_e                  state_q;
   logic [WIDTH-1:0]        count_q;
   logic [PRESCALE_W-1:0]   pre_q;
   logic                    tick_q;
   logic                    ready_q;
   logic [WIDTH-1:0]        period_q;
   logic [PRESCALE_W-1:0]   prescale_q;
   logic                    periodic_q;

   logic cmd_accept;
   logic cmd_fire;

   // Only commands that change something pre-empt the prescaler on this edge;
   // an ignored PAUSE/RESUME leaves counting untouched.
   assign cmd_accept = cmd_valid && ready_q;
   always_comb begin
      cmd_fire = 1'b0;
      if (cmd_accept) begin
         unique case (cmd_op)
            OP_START:  cmd_fire = 1'b1;
            OP_STOP:   cmd_fire = 1'b1;
            OP_PAUSE:  cmd_fire = (state_q == ST_RUN);
            OP_RESUME: cmd_fire = (state_q == ST_PAUSED);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         pre_q      <= '0;
         tick_q     <= 1'b0;
         ready_q    <= 1'b0;
         period_q   <= '0;
         prescale_q <= '0;
         periodic_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         tick_q  <= 1'b0;
         if (cmd_fire) begin
            unique case (cmd_op)
               OP_START: begin
                  period_q   <= period;
                  prescale_q <= prescale;
                  periodic_q <= periodic;
                  count_q    <= '0;
                  pre_q      <= '0;
                  state_q    <= ST_RUN;
               end
               OP_STOP: begin
                  count_q <= '0;
                  pre_q   <= '0;
                  state_q <= ST_IDLE;
               end
               OP_PAUSE:  state_q <= ST_PAUSED;
               OP_RESUME: state_q <= ST_RUN;
            endcase
         end else if (state_q == ST_RUN) begin
            if (pre_q == prescale_q) begin
               pre_q <= '0;
               if (count_q == period_q) begin
                  tick_q <= 1'b1;
                  if (periodic_q) count_q <= '0;
                  else            state_q <= ST_DONE;
               end else begin
                  count_q <= count_q + CNT_ONE;
               end
            end else begin
               pre_q <= pre_q + PRE_ONE;
            end
         end
      end
   end

   assign cmd_ready = ready_q;
   assign count     = count_q;
   assign tick      = tick_q;
   assign state     = state_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSED);

`ifdef MICROMIND_COUNT_CAPTURE_EN
   logic [WIDTH-1:0] cap_value_q;
   logic             cap_valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_value_q <= '0;
         cap_valid_q <= 1'b0;
      end else if (capture) begin
         cap_value_q <= count_q;
         cap_valid_q <= 1'b1;
      end else if (cmd_accept && (cmd_op == OP_START || cmd_op == OP_STOP)) begin
         cap_valid_q <= 1'b0;
      end
   end

   assign cap_value = cap_value_q;
   assign cap_valid = cap_valid_q;
`endif

endmodule
`default_nettype wire

// File: doc/micromind_count_ctrl.md
Name: micromind_count_ctrl

Overview:
- Command-driven sequencer for the micromind up-counter datapath: start, stop, pause, resume, prescale, terminal count, one-shot or periodic mode.
- Owns the count register plus a prescaler. Emits a one-cycle tick at each terminal count.
- Sits between the host/bus command interface and downstream consumers of count/tick.

Parameters:
WIDTH, 8, width of count and period
PRESCALE_W, 4, width of prescale divider field

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge
cmd_op  input  2  00 START, 01 STOP, 10 PAUSE, 11 RESUME
period  input  WIDTH  terminal count, captured on START
prescale  input  PRESCALE_W  divide ratio minus 1, captured on START
periodic  input  1  1 = auto-reload, 0 = one-shot; captured on START
count  output  WIDTH  current count value
tick  output  1  registered one-cycle pulse at terminal count
busy  output  1  high in RUN or PAUSED
state  output  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE

Behaviour:
- Reset: clk and reset are the only timing/reset inputs; reset is synchronous and active-high. While reset is high at a posedge, all of the following are forced:
  - state=IDLE, count=0, prescaler=0, tick=0, cmd_ready=0, captured period/prescale/periodic=0.
  - busy=0 (busy is decoded from state).
- cmd_ready: registered. 0 while reset is asserted; 1 from the first posedge with reset low, held 1 thereafter. Every offered command is accepted in one cycle. Commands illegal in the current state are accepted and ignored.
- START, any state: capture period/prescale/periodic; count<=0, prescaler<=0, state<=RUN. Accepted at edge N gives RUN with count=0 visible after N.
- STOP, any state: state<=IDLE, count<=0, prescaler<=0.
- PAUSE: effective only in RUN. state<=PAUSED; count and prescaler hold.
- RESUME: effective only in PAUSED. state<=RUN; counting continues from held values.
- Prescaler in RUN, each edge:
  - If prescaler==prescale: prescaler<=0 and a count step occurs.
  - Otherwise prescaler+1.
- Count step:
  - If count!=period: count<=count+1.
  - If count==period (terminal): tick<=1 for exactly one cycle.
    - periodic=1: count<=0, stay RUN.
    - periodic=0: count holds period, state<=DONE.
- Tick period in periodic mode = (period+1)*(prescale+1) clocks.
- Edge case period=0: every step is terminal; count stays 0.
- IDLE, DONE, PAUSED: no stepping; tick=0.
- Simultaneous accepted command and count step on the same edge: the command wins.
  - START/STOP: act as defined above.
  - PAUSE: no step, no tick.
  - No tick is emitted on that edge.
- Arithmetic: count wraps mod 2^WIDTH, which is unreachable because terminal ≤ 2^WIDTH-1. All comparisons are unsigned.
- Reset mid-RUN/PAUSED: reset values at the next edge; any pending tick is cleared.

Optional Feature:
- Macro: MICROMIND_COUNT_CAPTURE_EN.
- Defined: adds these ports:
  - capture (input, 1)
  - cap_value (output, WIDTH, reset 0)
  - cap_valid (output, 1, reset 0)
- Defined, behaviour:
  - capture high at an edge latches the current (pre-update) count into cap_value and sets cap_valid=1.
  - cap_valid clears on START or STOP. Capture wins if it occurs on the same edge.
- Undefined: ports absent, no capture logic.

Test Plan:
- Reset then START period=3 prescale=0 periodic=1 → count 0,1,2,3,0 on successive edges; tick high for the one cycle after each 3→0 edge, every 4 clocks; busy=1, state=01.
- START period=2 prescale=2 periodic=0 → count steps every 3 clocks 0,1,2; single tick; state=11, count holds 2, busy=0.
- RUN at count=5, PAUSE, wait 10 clocks, RESUME → count stays 5 while state=10, then resumes 6,7…; RESUME issued in IDLE is ignored.
- PAUSE accepted on the same edge as the terminal step (count==period) → state=10, count unchanged, no tick; STOP accepted mid-RUN → count=0, state=00 next edge.
- Assert reset for 1 cycle while RUN with a tick due → all outputs 0, cmd_ready=0 during reset, 1 after; period=0 START → tick every prescale+1 clocks, count=0.
- With MICROMIND_COUNT_CAPTURE_EN: capture at count=7 → cap_value=7, cap_valid=1; next START → cap_valid=0.
